// File: rtl/bool_sweep_checker.sv
// Exhaustive sweep sequencer: drives every N_IN-bit vector into three boolean implementations
// and compares their F outputs. Optional macro HALT_ON_FAIL_EN stops the sweep at the first mismatch.
module bool_sweep_checker #(
  parameter int N_IN       = 3,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             F_dataflow,
  input  logic             F_behavioral,
  input  logic             F_structural,
  output logic [N_IN-1:0]  vec_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             first_fail_vld
);

  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

`ifdef HALT_ON_FAIL_EN
  localparam bit HALT_ON_FAIL = 1'b1;
`else
  localparam bit HALT_ON_FAIL = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [SC_W-1:0]   settle_cnt;
  logic              mismatch;
  logic              settle_last;
  logic              vec_last;

  assign mismatch    = !(F_dataflow == F_behavioral && F_behavioral == F_structural);
  assign settle_last = (settle_cnt == SC_W'(SETTLE_CYC - 1));
  assign vec_last    = &vec_out;
  assign busy        = (state == S_SETTLE) || (state == S_CHECK);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start && !abort) state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (abort)            state_nxt = S_IDLE;
        else if (settle_last) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (abort)                         state_nxt = S_IDLE;
        else if (HALT_ON_FAIL && mismatch) state_nxt = S_DONE;
        else if (vec_last)                 state_nxt = S_DONE;
        else                               state_nxt = S_SETTLE;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_out        <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_cnt   <= '0;
      first_fail_vec <= '0;
      first_fail_vld <= 1'b0;
      settle_cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            vec_out        <= '0;
            mismatch_cnt   <= '0;
            pass           <= 1'b0;
            first_fail_vld <= 1'b0;
            settle_cnt     <= '0;
          end
        end
        S_SETTLE: begin
          if (abort)            pass       <= 1'b0;
          else if (settle_last) settle_cnt <= '0;
          else                  settle_cnt <= settle_cnt + SC_W'(1);
        end
        S_CHECK: begin
          if (abort) begin
            pass <= 1'b0;
          end else begin
            if (mismatch) begin
              if (mismatch_cnt != {CNT_W{1'b1}}) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
              if (!first_fail_vld) begin
                first_fail_vec <= vec_out;
                first_fail_vld <= 1'b1;
              end
            end
            // Advance only when another vector follows; a finished or halted sweep keeps vec_out.
            if (state_nxt == S_SETTLE) vec_out <= vec_out + N_IN'(1);
          end
        end
        S_DONE: begin
          done <= 1'b1;
          pass <= (mismatch_cnt == '0);
        end
        default: ;
      endcase
    end
  end

endmodule
